// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg
// Shared definitions for the multi-counter state table and its host block.
//   OP_OUTPUT_B : bit of op_t that marks an operation as producing a query
//                 result on the counter's status stream.
//   op_t        : counter operation encoding. Bit 2 set means "query".
package multi_counter_pkg;

  localparam int OP_OUTPUT_B = 2;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_INIT       = 3'd1,
    OP_INCR       = 3'd2,
    OP_DECR       = 3'd3,
    OP_QUERY      = 3'd4,
    OP_INIT_QUERY = 3'd5,
    OP_INCR_QUERY = 3'd6,
    OP_DECR_QUERY = 3'd7
  } op_t;

endpackage

// File: rtl/multi_counter_host_if.sv
// multi_counter_host_if
// Host-side bundle of multi_counter_host: the request channel (valid/ready)
// and the response channel (valid/ready).
//   req_vld/req_rdy/req_id/req_op/req_dat : counter request from the host
//   rsp_vld/rsp_rdy/rsp_id/rsp_dat        : query result returned to the host
// Modports:
//   master : the host (drives requests, consumes responses)
//   slave  : multi_counter_host
interface multi_counter_host_if
  import multi_counter_pkg::*;
#(
  parameter int CNTRS_ID_W = 8,
  parameter int CNTRS_W    = 32
);

  logic                  req_vld;
  logic                  req_rdy;
  logic [CNTRS_ID_W-1:0] req_id;
  op_t                   req_op;
  logic [CNTRS_W-1:0]    req_dat;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [CNTRS_ID_W-1:0] rsp_id;
  logic [CNTRS_W-1:0]    rsp_dat;

  modport master (
    output req_vld, req_id, req_op, req_dat, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_dat
  );

  modport slave (
    input  req_vld, req_id, req_op, req_dat, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_dat
  );

endinterface

// File: rtl/multi_counter_host.sv
// multi_counter_host
// Command-side initiator and status-side consumer for the multi-counter
// state table. Host requests become single-cycle cntr_* commands; query
// results coming back on the status_* stream are captured in a response
// FIFO that the host drains. The counter pipeline cannot stall, so a query
// is only accepted while a FIFO slot is guaranteed for its result
// (credits = RSP_DEPTH - (fifo_count + outstanding)).
//
// Ports:
//   clk            : clock
//   rst            : asynchronous reset, active-low
//   host (slave)   : req_* request channel, rsp_* response channel
//   cntr_pass/id/op/dat : registered command to the counter table
//   status_pass_r/qry_r/id_r/dat_r : status beats from the counter table
//   err_unexp_r    : sticky, query result seen with nothing outstanding
//   err_id_r       : sticky, result ID differs from the expected ID
//
// Optional feature: define MULTI_COUNTER_HOST_IDCHK_EN to keep an
// expected-ID FIFO and flag result IDs that do not match the issued order.
// Without it err_id_r is tied to 0.
module multi_counter_host
  import multi_counter_pkg::*;
#(
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_counter_host_if.slave   host,
  output logic                  cntr_pass,
  output logic [CNTRS_ID_W-1:0] cntr_id,
  output op_t                   cntr_op,
  output logic [CNTRS_W-1:0]    cntr_dat,
  input  logic                  status_pass_r,
  input  logic                  status_qry_r,
  input  logic [CNTRS_ID_W-1:0] status_id_r,
  input  logic [CNTRS_W-1:0]    status_dat_r,
  output logic                  err_unexp_r,
  output logic                  err_id_r
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(RSP_DEPTH);

  // A credit exists while issued-but-unreturned queries plus buffered
  // results leave at least one free FIFO slot.
  function automatic logic credit_avail(input logic [CNT_W-1:0] fifo_n,
                                        input logic [CNT_W-1:0] outst_n);
    logic [CNT_W:0] used;
    used = {1'b0, fifo_n} + {1'b0, outst_n};
    return (used < DEPTH_L);
  endfunction

  logic                  run_q;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNTRS_ID_W-1:0] rsp_id_mem  [RSP_DEPTH];
  logic [CNTRS_W-1:0]    rsp_dat_mem [RSP_DEPTH];

  logic is_qry;
  logic accept;
  logic issue;
  logic qry_issue;
  logic beat_qry;
  logic ret;
  logic unexp;
  logic fifo_nempty;
  logic pop;

  // ---------------------------------------------------------------------
  // Request side: ready depends on registered state and the offered op.
  // ---------------------------------------------------------------------
  assign is_qry       = host.req_op[OP_OUTPUT_B];
  assign host.req_rdy = run_q & (~is_qry | credit_avail(fifo_count, outstanding));
  assign accept       = host.req_vld & host.req_rdy;
  assign issue        = accept & (host.req_op != OP_NOP);
  assign qry_issue    = accept & is_qry;

  // Status side: a query beat is only legitimate while something is owed.
  assign beat_qry = status_pass_r & status_qry_r;
  assign ret      = beat_qry & (outstanding != '0);
  assign unexp    = beat_qry & (outstanding == '0);

  // Response side
  assign fifo_nempty  = (fifo_count != '0);
  assign pop          = fifo_nempty & host.rsp_rdy;
  assign host.rsp_vld = fifo_nempty;
  assign host.rsp_id  = fifo_nempty ? rsp_id_mem[rd_ptr]  : '0;
  assign host.rsp_dat = fifo_nempty ? rsp_dat_mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------
  // Issue register stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      cntr_pass <= 1'b0;
      cntr_id   <= '0;
      cntr_op   <= OP_NOP;
      cntr_dat  <= '0;
    end else begin
      run_q     <= 1'b1;
      cntr_pass <= issue;
      if (issue) begin
        cntr_id  <= host.req_id;
        cntr_op  <= host.req_op;
        cntr_dat <= host.req_dat;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Credit / response FIFO control stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_unexp_r <= 1'b0;
    end else begin
      case ({qry_issue, ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      case ({ret, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (ret) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (unexp) err_unexp_r <= 1'b1;
    end
  end

  // Storage carries no reset; the read side masks it while empty.
  always_ff @(posedge clk) begin
    if (ret) begin
      rsp_id_mem[wr_ptr]  <= status_id_r;
      rsp_dat_mem[wr_ptr] <= status_dat_r;
    end
  end

`ifdef MULTI_COUNTER_HOST_IDCHK_EN
  // ---------------------------------------------------------------------
  // Expected-ID FIFO stage: occupancy always equals outstanding, so it can
  // neither overflow nor be read empty on an accepted return.
  // ---------------------------------------------------------------------
  logic [CNTRS_ID_W-1:0] exp_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      exp_wr_ptr;
  logic [PTR_W-1:0]      exp_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_wr_ptr <= '0;
      exp_rd_ptr <= '0;
      err_id_r   <= 1'b0;
    end else begin
      if (qry_issue) exp_wr_ptr <= exp_wr_ptr + 1'b1;
      if (ret) begin
        exp_rd_ptr <= exp_rd_ptr + 1'b1;
        if (status_id_r != exp_mem[exp_rd_ptr]) err_id_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (qry_issue) exp_mem[exp_wr_ptr] <= host.req_id;
  end
`else
  assign err_id_r = 1'b0;
`endif

  // Credit gating makes these unreachable; catch any regression early.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(ret && (fifo_count == DEPTH_L[CNT_W-1:0])));
      assert (!(pop && !fifo_nempty));
      assert (!(qry_issue && !credit_avail(fifo_count, outstanding)));
    end
  end

endmodule

// File: tb/tb_multi_counter_host.sv
module tb_multi_counter_host;
  import multi_counter_pkg::*;

  localparam int ID_W = 8;
  localparam int DW   = 32;

`ifdef MULTI_COUNTER_HOST_IDCHK_EN
  localparam logic EXP_IDERR = 1'b1;
`else
  localparam logic EXP_IDERR = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            cntr_pass;
  logic [ID_W-1:0] cntr_id;
  op_t             cntr_op;
  logic [DW-1:0]   cntr_dat;
  logic            status_pass_r;
  logic            status_qry_r;
  logic [ID_W-1:0] status_id_r;
  logic [DW-1:0]   status_dat_r;
  logic            err_unexp_r;
  logic            err_id_r;

  int checks = 0;
  int errors = 0;

  multi_counter_host_if #(.CNTRS_ID_W(ID_W), .CNTRS_W(DW)) hif ();

  multi_counter_host #(
    .CNTRS_N(256), .CNTRS_W(DW), .CNTRS_ID_W(ID_W), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .host(hif.slave),
    .cntr_pass(cntr_pass), .cntr_id(cntr_id), .cntr_op(cntr_op), .cntr_dat(cntr_dat),
    .status_pass_r(status_pass_r), .status_qry_r(status_qry_r),
    .status_id_r(status_id_r), .status_dat_r(status_dat_r),
    .err_unexp_r(err_unexp_r), .err_id_r(err_id_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_status(input logic [ID_W-1:0] id, input logic [DW-1:0] dat);
    status_pass_r = 1'b1; status_qry_r = 1'b1; status_id_r = id; status_dat_r = dat;
    tick();
    status_pass_r = 1'b0; status_qry_r = 1'b0;
  endtask

  task automatic test_reset();
    hif.req_op = OP_INCR;
    #1;
    checks++; if (hif.req_rdy !== 1'b0) begin errors++; $display("FAIL reset_req_rdy: got %0h expected 0", hif.req_rdy); end
    checks++; if (cntr_pass !== 1'b0) begin errors++; $display("FAIL reset_cntr_pass: got %0h expected 0", cntr_pass); end
    checks++; if (cntr_id !== 8'h00) begin errors++; $display("FAIL reset_cntr_id: got %0h expected 0", cntr_id); end
    checks++; if (cntr_op !== OP_NOP) begin errors++; $display("FAIL reset_cntr_op: got %0h expected 0", cntr_op); end
    checks++; if (cntr_dat !== 32'h0) begin errors++; $display("FAIL reset_cntr_dat: got %0h expected 0", cntr_dat); end
    checks++; if (hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %0h expected 0", hif.rsp_vld); end
    checks++; if (hif.rsp_id !== 8'h00) begin errors++; $display("FAIL reset_rsp_id: got %0h expected 0", hif.rsp_id); end
    checks++; if (hif.rsp_dat !== 32'h0) begin errors++; $display("FAIL reset_rsp_dat: got %0h expected 0", hif.rsp_dat); end
    checks++; if (err_unexp_r !== 1'b0) begin errors++; $display("FAIL reset_err_unexp: got %0h expected 0", err_unexp_r); end
    checks++; if (err_id_r !== 1'b0) begin errors++; $display("FAIL reset_err_id: got %0h expected 0", err_id_r); end
    rst = 1'b1;
    tick();
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy_incr: got %0h expected 1", hif.req_rdy); end
    hif.req_op = OP_QUERY;
    #1;
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy_query: got %0h expected 1", hif.req_rdy); end
  endtask

  task automatic test_init_query();
    hif.req_vld = 1'b1; hif.req_op = OP_INIT; hif.req_id = 8'd5; hif.req_dat = 32'h10;
    tick();
    hif.req_vld = 1'b0;
    checks++; if (cntr_pass !== 1'b1) begin errors++; $display("FAIL init_pass: got %0h expected 1", cntr_pass); end
    checks++; if (cntr_id !== 8'd5) begin errors++; $display("FAIL init_id: got %0h expected 5", cntr_id); end
    checks++; if (cntr_op !== OP_INIT) begin errors++; $display("FAIL init_op: got %0h expected 1", cntr_op); end
    checks++; if (cntr_dat !== 32'h10) begin errors++; $display("FAIL init_dat: got %0h expected 10", cntr_dat); end
    tick();
    checks++; if (cntr_pass !== 1'b0) begin errors++; $display("FAIL init_pass_one_cycle: got %0h expected 0", cntr_pass); end
    hif.req_vld = 1'b1; hif.req_op = OP_QUERY; hif.req_id = 8'd5; hif.req_dat = 32'h0;
    tick();
    hif.req_vld = 1'b0;
    checks++; if (cntr_pass !== 1'b1 || cntr_op !== OP_QUERY) begin errors++; $display("FAIL query_issue: got pass=%0h op=%0h expected pass=1 op=4", cntr_pass, cntr_op); end
    send_status(8'd5, 32'h10);
    checks++; if (hif.rsp_vld !== 1'b1) begin errors++; $display("FAIL query_rsp_vld: got %0h expected 1", hif.rsp_vld); end
    checks++; if (hif.rsp_id !== 8'd5) begin errors++; $display("FAIL query_rsp_id: got %0h expected 5", hif.rsp_id); end
    checks++; if (hif.rsp_dat !== 32'h10) begin errors++; $display("FAIL query_rsp_dat: got %0h expected 10", hif.rsp_dat); end
    hif.rsp_rdy = 1'b1;
    tick();
    hif.rsp_rdy = 1'b0;
    checks++; if (hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL query_pop_empty: got %0h expected 0", hif.rsp_vld); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    hif.rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hif.req_vld = 1'b1; hif.req_op = OP_QUERY; hif.req_id = 8'(10 + i); hif.req_dat = 32'h0;
      #1;
      exp_rdy = (i < 4);
      checks++; if (hif.req_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_rdy_%0d: got %0h expected %0h", i, hif.req_rdy, exp_rdy); end
      if (i < 4) tick();
    end
    checks++; if (cntr_pass !== 1'b1 || cntr_id !== 8'd13) begin errors++; $display("FAIL b2b_last_issue: got pass=%0h id=%0h expected pass=1 id=d", cntr_pass, cntr_id); end
    for (int j = 0; j < 4; j++) send_status(8'(10 + j), 32'h100 + 32'(j));
    #1;
    checks++; if (hif.req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full: got %0h expected 0", hif.req_rdy); end
    checks++; if (cntr_pass !== 1'b0) begin errors++; $display("FAIL b2b_blocked_no_issue: got %0h expected 0", cntr_pass); end
    checks++; if (hif.rsp_vld !== 1'b1 || hif.rsp_id !== 8'd10 || hif.rsp_dat !== 32'h100) begin errors++; $display("FAIL b2b_head0: got vld=%0h id=%0h dat=%0h expected 1 a 100", hif.rsp_vld, hif.rsp_id, hif.rsp_dat); end
    hif.rsp_rdy = 1'b1;
    tick();
    hif.rsp_rdy = 1'b0;
    #1;
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_credit_after_pop: got %0h expected 1", hif.req_rdy); end
    tick();
    hif.req_vld = 1'b0;
    checks++; if (cntr_pass !== 1'b1 || cntr_id !== 8'd14) begin errors++; $display("FAIL b2b_fifth_issue: got pass=%0h id=%0h expected pass=1 id=e", cntr_pass, cntr_id); end
    send_status(8'd14, 32'h104);
    for (int k = 0; k < 4; k++) begin
      checks++; if (hif.rsp_vld !== 1'b1 || hif.rsp_id !== 8'(11 + k) || hif.rsp_dat !== 32'h101 + 32'(k)) begin errors++; $display("FAIL b2b_order_%0d: got vld=%0h id=%0h dat=%0h expected id=%0h dat=%0h", k, hif.rsp_vld, hif.rsp_id, hif.rsp_dat, 11 + k, 32'h101 + 32'(k)); end
      hif.rsp_rdy = 1'b1;
      tick();
      hif.rsp_rdy = 1'b0;
    end
    checks++; if (hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0h expected 0", hif.rsp_vld); end
  endtask

  task automatic test_nonquery_bypass();
    for (int i = 0; i < 4; i++) begin
      hif.req_vld = 1'b1; hif.req_op = OP_QUERY; hif.req_id = 8'(20 + i);
      tick();
    end
    hif.req_id = 8'd24;
    #1;
    checks++; if (hif.req_rdy !== 1'b0) begin errors++; $display("FAIL bypass_query_blocked: got %0h expected 0", hif.req_rdy); end
    hif.req_op = OP_INCR; hif.req_id = 8'd7;
    #1;
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL bypass_incr_rdy: got %0h expected 1", hif.req_rdy); end
    tick();
    checks++; if (cntr_pass !== 1'b1 || cntr_op !== OP_INCR || cntr_id !== 8'd7) begin errors++; $display("FAIL bypass_incr_issue: got pass=%0h op=%0h id=%0h expected 1 2 7", cntr_pass, cntr_op, cntr_id); end
    hif.req_op = OP_NOP; hif.req_id = 8'd9;
    #1;
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL bypass_nop_rdy: got %0h expected 1", hif.req_rdy); end
    tick();
    hif.req_vld = 1'b0;
    checks++; if (cntr_pass !== 1'b0 || cntr_id !== 8'd7) begin errors++; $display("FAIL bypass_nop_dropped: got pass=%0h id=%0h expected pass=0 id=7", cntr_pass, cntr_id); end
  endtask

  task automatic test_full_swap();
    for (int i = 0; i < 3; i++) send_status(8'(20 + i), 32'h200 + 32'(i));
    hif.req_op = OP_QUERY;
    #1;
    checks++; if (hif.req_rdy !== 1'b0) begin errors++; $display("FAIL swap_pre_rdy: got %0h expected 0", hif.req_rdy); end
    hif.rsp_rdy = 1'b1;
    send_status(8'd23, 32'h203);
    hif.rsp_rdy = 1'b0;
    #1;
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL swap_credit: got %0h expected 1", hif.req_rdy); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (hif.rsp_vld !== 1'b1 || hif.rsp_id !== 8'(21 + k) || hif.rsp_dat !== 32'h201 + 32'(k)) begin errors++; $display("FAIL swap_order_%0d: got vld=%0h id=%0h dat=%0h expected id=%0h dat=%0h", k, hif.rsp_vld, hif.rsp_id, hif.rsp_dat, 21 + k, 32'h201 + 32'(k)); end
      hif.rsp_rdy = 1'b1;
      tick();
      hif.rsp_rdy = 1'b0;
    end
    checks++; if (hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL swap_drained: got %0h expected 0", hif.rsp_vld); end
    checks++; if (err_unexp_r !== 1'b0) begin errors++; $display("FAIL swap_no_unexp: got %0h expected 0", err_unexp_r); end
  endtask

  task automatic test_unexp();
    status_pass_r = 1'b1; status_qry_r = 1'b0; status_id_r = 8'd1; status_dat_r = 32'h77;
    tick();
    status_pass_r = 1'b0;
    checks++; if (err_unexp_r !== 1'b0 || hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL unexp_nonqry_ignored: got err=%0h vld=%0h expected 0 0", err_unexp_r, hif.rsp_vld); end
    send_status(8'd1, 32'h77);
    checks++; if (err_unexp_r !== 1'b1 || hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL unexp_set: got err=%0h vld=%0h expected 1 0", err_unexp_r, hif.rsp_vld); end
    repeat (3) tick();
    checks++; if (err_unexp_r !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %0h expected 1", err_unexp_r); end
    hif.req_vld = 1'b1; hif.req_op = OP_QUERY; hif.req_id = 8'd30;
    tick();
    hif.req_vld = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (cntr_pass !== 1'b0 || err_unexp_r !== 1'b0 || hif.req_rdy !== 1'b0) begin errors++; $display("FAIL midreset_clear: got pass=%0h err=%0h rdy=%0h expected 0 0 0", cntr_pass, err_unexp_r, hif.req_rdy); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (hif.req_rdy !== 1'b1) begin errors++; $display("FAIL midreset_rdy: got %0h expected 1", hif.req_rdy); end
    send_status(8'd30, 32'h0);
    checks++; if (err_unexp_r !== 1'b1 || hif.rsp_vld !== 1'b0) begin errors++; $display("FAIL stale_beat: got err=%0h vld=%0h expected 1 0", err_unexp_r, hif.rsp_vld); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (err_unexp_r !== 1'b0) begin errors++; $display("FAIL unexp_cleared: got %0h expected 0", err_unexp_r); end
  endtask

  task automatic test_idchk();
    hif.req_vld = 1'b1; hif.req_op = OP_QUERY; hif.req_id = 8'd3;
    tick();
    hif.req_vld = 1'b0;
    send_status(8'd4, 32'h55);
    checks++; if (hif.rsp_vld !== 1'b1 || hif.rsp_id !== 8'd4 || hif.rsp_dat !== 32'h55) begin errors++; $display("FAIL idchk_delivered: got vld=%0h id=%0h dat=%0h expected 1 4 55", hif.rsp_vld, hif.rsp_id, hif.rsp_dat); end
    checks++; if (err_id_r !== EXP_IDERR) begin errors++; $display("FAIL idchk_err: got %0h expected %0h", err_id_r, EXP_IDERR); end
    hif.rsp_rdy = 1'b1;
    tick();
    hif.rsp_rdy = 1'b0;
    hif.req_vld = 1'b1; hif.req_op = OP_INCR_QUERY; hif.req_id = 8'd6;
    tick();
    hif.req_vld = 1'b0;
    send_status(8'd6, 32'h66);
    checks++; if (hif.rsp_id !== 8'd6 || err_id_r !== EXP_IDERR) begin errors++; $display("FAIL idchk_match_sticky: got id=%0h err=%0h expected 6 %0h", hif.rsp_id, err_id_r, EXP_IDERR); end
    hif.rsp_rdy = 1'b1;
    tick();
    hif.rsp_rdy = 1'b0;
    checks++; if (hif.rsp_vld !== 1'b0 || err_unexp_r !== 1'b0) begin errors++; $display("FAIL idchk_end: got vld=%0h unexp=%0h expected 0 0", hif.rsp_vld, err_unexp_r); end
  endtask

  initial begin
    rst = 1'b0;
    hif.req_vld = 1'b0; hif.req_op = OP_NOP; hif.req_id = '0; hif.req_dat = '0;
    hif.rsp_rdy = 1'b0;
    status_pass_r = 1'b0; status_qry_r = 1'b0; status_id_r = '0; status_dat_r = '0;
    repeat (2) tick();
    test_reset();
    test_init_query();
    test_back_to_back();
    test_nonquery_bypass();
    test_full_swap();
    test_unexp();
    test_idchk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_counter_host.md
# multi_counter_host

Command-side initiator and status-side consumer for the multi-counter state table. It accepts counter requests from a host over a valid/ready handshake and issues them as single-cycle `cntr_*` commands. It captures query results from the counter's `status_*` stream into a response FIFO that the host drains over valid/ready. The counter pipeline cannot stall, so query issue is credit-gated: an accepted query always has a guaranteed FIFO slot.

## Interface
Parameters:
- `CNTRS_N`, 256, number of counters
- `CNTRS_W`, 32, counter width
- `CNTRS_ID_W`, `$clog2(CNTRS_N)`, counter ID width
- `RSP_DEPTH`, 4, response FIFO depth and query-credit count; power of two, ≥2

Ports:
- `clk` in 1 — the single clock
- `rst` in 1 — reset, asynchronous, active-low
- `req_vld` in 1 — host request valid
- `req_rdy` out 1 — host request ready
- `req_id` in `CNTRS_ID_W` — target counter
- `req_op` in `multi_counter_pkg::op_t` — operation
- `req_dat` in `CNTRS_W` — INIT value
- `cntr_pass` out 1 — command valid (registered)
- `cntr_id` out `CNTRS_ID_W` — command ID (registered)
- `cntr_op` out `op_t` — command op (registered)
- `cntr_dat` out `CNTRS_W` — command data (registered)
- `status_pass_r` in 1 — status beat valid
- `status_qry_r` in 1 — beat carries a query result
- `status_id_r` in `CNTRS_ID_W` — result ID
- `status_dat_r` in `CNTRS_W` — result value
- `rsp_vld` out 1 — response available
- `rsp_rdy` in 1 — host consumes response
- `rsp_id` out `CNTRS_ID_W` — response ID
- `rsp_dat` out `CNTRS_W` — response value
- `err_unexp_r` out 1 — sticky: query result arrived with no outstanding query
- `err_id_r` out 1 — sticky: result ID differs from expected ID (see Configuration)

## Operation
- Accept when `req_vld & req_rdy` at a rising edge.
- Query op: `req_op[OP_OUTPUT_B]` set.
- Credits: `RSP_DEPTH - (fifo_count + outstanding)`. `outstanding` counts queries issued but not yet returned.
- `req_rdy`:
  - Query: 1 iff credits ≠ 0.
  - Any other op: always 1 when out of reset.
  - Depends only on registered state, never on `req_vld`.
- Accepted `OP_NOP`: consumed and dropped; `cntr_pass` stays 0.
- Accepted non-NOP: the issue register loads id/op/dat, and `cntr_pass`=1 for exactly the next cycle.
- Query issue: increments `outstanding`. With IDCHK, `req_id` is pushed to the expected-ID FIFO.
- `status_pass_r & status_qry_r` with `outstanding` ≠ 0:
  - Push `{status_id_r, status_dat_r}` into the response FIFO.
  - Decrement `outstanding`.
- `status_pass_r & status_qry_r` with `outstanding` = 0: drop the beat and set `err_unexp_r`.
- Status beats with `status_qry_r`=0 are ignored.
- Same-cycle issue and return: `outstanding` is unchanged.
- FIFO push and pop in the same cycle: count is unchanged. Pop-when-empty and push-when-full are impossible by construction; assert on them.
- `rsp_vld` = FIFO not empty. `rsp_id`/`rsp_dat` show the head entry; the entry pops on `rsp_vld & rsp_rdy`.
- Response order equals query issue order.
- Counters: `outstanding` and `fifo_count` are `$clog2(RSP_DEPTH)+1` bits wide. FIFO pointers wrap modulo `RSP_DEPTH`.

## Timing
- Reset values:
  - `cntr_pass`, `cntr_id`, `cntr_op`, `cntr_dat` = 0
  - `rsp_vld`, `rsp_id`, `rsp_dat` = 0
  - `err_unexp_r`, `err_id_r` = 0
  - `req_rdy` = 0 while `rst` is low; 1 from the first cycle after release
  - `outstanding` = 0; FIFOs empty
- Request accepted at edge T → `cntr_pass`=1 during cycle T..T+1.
- Issue throughput: one command per cycle.
- Status beat sampled at edge S → `rsp_vld`=1 from S (registered FIFO, zero bubble when empty).
- Credit release:
  - By pop: a pop at edge P frees a credit, so `req_rdy` for a query can rise after P.
  - By accept: a query accepted at T consumes a credit visible after T.
- Reset asserted mid-operation clears all state immediately. Status beats for pre-reset queries that arrive afterward set `err_unexp_r` and are dropped.
- Sticky errors clear only on reset.

## Configuration
- `MULTI_COUNTER_HOST_IDCHK_EN` defined:
  - An expected-ID FIFO (depth `RSP_DEPTH`) is pushed on query issue and popped on each accepted query result.
  - A result ID ≠ the head entry sets `err_id_r`; the response is still delivered.
- Not defined: no expected-ID storage; `err_id_r` is tied to 0.

## Test plan
- Reset release, then INIT id=5 dat=0x10 → one-cycle `cntr_pass` with id=5, dat=0x10. Then query id=5; stub returns `status_qry_r`, id=5, dat=0x10 → `rsp_vld`=1, `rsp_id`=5, `rsp_dat`=0x10.
- `rsp_rdy`=0, `RSP_DEPTH`=4: five back-to-back queries → four accepted, `req_rdy`=0 on the 5th. A single pop → 5th accepted the next cycle. All responses returned in issue order.
- Query and INCR with `req_rdy` low for queries → INCR still accepted. NOP accepted → no `cntr_pass`.
- Status beat returned and FIFO popped in the same cycle while full → count unchanged, no overflow assertion, `outstanding` correct.
- Query result injected with `outstanding`=0 → dropped, `err_unexp_r`=1 until reset.
- IDCHK build: query id=3 issued, stub returns id=4 → `err_id_r`=1, `rsp_id`=4 delivered. Non-IDCHK build: `err_id_r` stays 0.
